// File: rtl/rom_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rom_pkg
// Brief    : Shared widths, types and state encoding for the ROM burst reader.
// Revision : 1.0 - initial release
// ============================================================================
package rom_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int LANES  = 10;
  localparam int LEN_W  = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [LEN_W-1:0]  len_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_LAST = 2'd2
  } rd_state_e;

  // Words consumed by one beat: a full beat, or whatever is left.
  function automatic len_t lanes_used(input len_t remaining);
    return (remaining < len_t'(LANES)) ? remaining : len_t'(LANES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_burst_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rom_burst_reader_if
// Brief    : ROM address/data bus plus the valid/ready output beat stream.
// Revision : 1.0 - initial release
// ============================================================================
interface rom_burst_reader_if;
  import rom_pkg::*;

  logic [LANES*ADDR_W-1:0] rom_addr;
  logic [LANES*DATA_W-1:0] rom_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_mask;
  logic                    out_last;

  modport master (
    output rom_addr,
    input  rom_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_mask,
    output out_last
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_mask,
    input  out_last
  );

endinterface
`default_nettype wire

// File: rtl/rom_lane_addr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rom_lane_addr_gen
// Brief    : Expands one cursor into LANES consecutive ROM addresses, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module rom_lane_addr_gen
  import rom_pkg::*;
(
  input  wire addr_t                   cursor,
  output wire [LANES*ADDR_W-1:0]       lane_addr
);

  // Plain ADDR_W-bit addition gives the modulo-2^ADDR_W wrap for free.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_addr[k*ADDR_W +: ADDR_W] = cursor + addr_t'(k);
  end

endmodule
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rom_burst_reader
// Brief    : Sweeps a 10-port combinational ROM and emits registered beats.
// Revision : 1.0 - initial release
// ============================================================================
module rom_burst_reader
  import rom_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            start,
  input  wire addr_t           base_addr,
  input  wire len_t            length,
  output wire                  busy,
  output wire                  done,
  rom_burst_reader_if.master   bus
);

  rd_state_e               state_q, state_d;
  addr_t                   cursor_q, cursor_d;
  len_t                    remaining_q, remaining_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]        out_mask_q, out_mask_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    free;
  logic [LANES-1:0]        cap_mask;
  logic [LANES*DATA_W-1:0] cap_data;
  logic                    cap_last;

  rom_lane_addr_gen u_addr_gen (
    .cursor    (cursor_q),
    .lane_addr (bus.rom_addr)
  );

  assign free     = !out_valid_q || bus.out_ready;
  assign cap_last = (remaining_q <= len_t'(LANES));

  // Lanes past the end of the transfer are zeroed rather than passed through.
  for (genvar k = 0; k < LANES; k++) begin : g_cap
    assign cap_mask[k]                  = (len_t'(k) < remaining_q);
    assign cap_data[k*DATA_W +: DATA_W] = cap_mask[k] ? bus.rom_data[k*DATA_W +: DATA_W]
                                                      : '0;
  end

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    busy_d      = done_q ? 1'b0 : busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (length != '0) begin
            cursor_d    = base_addr;
            remaining_d = length;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (free) begin
          out_valid_d = 1'b1;
          out_data_d  = cap_data;
          out_mask_d  = cap_mask;
          out_last_d  = cap_last;
          cursor_d    = cursor_q + addr_t'(LANES);
          remaining_d = remaining_q - lanes_used(remaining_q);
          if (cap_last) begin
            state_d = WAIT_LAST;
          end
        end
      end

      WAIT_LAST: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cursor_q    <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rom_burst_reader
// Brief    : Self-checking bench: vector table, random transfers, corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_burst_reader;
  import rom_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  start = 1'b0;
  addr_t base_addr = '0;
  len_t  length = '0;
  wire   busy;
  wire   done;

  rom_burst_reader_if bus ();

  rom_burst_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Image ROM model: an address hash, so a wrong address shows up as wrong data.
  function automatic word_t rom_word(input addr_t a);
    logic [31:0] t;
    t = {13'd0, a} * 32'h9E3779B1;
    return t[31:16];
  endfunction

  logic [LANES*DATA_W-1:0] rom_resp;
  always_comb begin
    rom_resp = '0;
    for (int k = 0; k < LANES; k++)
      rom_resp[k*DATA_W +: DATA_W] = rom_word(bus.rom_addr[k*ADDR_W +: ADDR_W]);
  end
  assign bus.rom_data = rom_resp;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [LANES*ADDR_W-1:0] exp_addrs(input int first);
    logic [LANES*ADDR_W-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*ADDR_W +: ADDR_W] = addr_t'(first + k);
    return v;
  endfunction

  // Beat b of a transfer: word i of the transfer lives at (base+i) mod 2^19.
  task automatic exp_beat(input addr_t b, input len_t n, input int beat,
                          output logic [LANES*DATA_W-1:0] d,
                          output logic [LANES-1:0] m, output logic l);
    d = '0;
    m = '0;
    for (int k = 0; k < LANES; k++) begin
      int idx;
      idx = beat * LANES + k;
      if (idx < int'(n)) begin
        d[k*DATA_W +: DATA_W] = rom_word(addr_t'(int'(b) + idx));
        m[k] = 1'b1;
      end
    end
    l = ((beat + 1) * LANES >= int'(n));
  endtask

  task automatic run_transfer(input string tag, input addr_t b, input len_t n, input int mode,
                              input int exp_beats, input logic [LANES-1:0] exp_last_mask,
                              input bit poke);
    int nb_model, seen, cyc, budget;
    bit last_taken, busy_ok, done_early, finished;
    logic [LANES*DATA_W-1:0] ed;
    logic [LANES-1:0] em, last_mask_seen;
    logic el;
    logic [4:0] pat;
    pat = 5'b11001;
    nb_model = (int'(n) + LANES - 1) / LANES;
    budget = nb_model * 10 + 30;
    seen = 0; cyc = 0; last_taken = 0; busy_ok = 1; done_early = 0; finished = 0;
    last_mask_seen = '0;

    @(negedge clk);
    start = 1'b1; base_addr = b; length = n;
    @(negedge clk);
    start = 1'b0;
    check({tag, " first rom_addr"}, 256'(bus.rom_addr), 256'(exp_addrs(int'(b))));

    while (!finished && cyc < budget) begin
      if (!busy) busy_ok = 0;
      if (last_taken) begin
        check({tag, " done pulse"}, 256'({bus.out_valid, done}), 256'(2'b01));
        finished = 1;
      end else begin
        if (done) done_early = 1;
        if (poke && cyc == 2) begin
          start = 1'b1; base_addr = b + 19'h123; length = 20'd7;
        end else begin
          start = 1'b0;
        end
        case (mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = 1'($urandom_range(0, 1));
          default: bus.out_ready = pat[cyc % 5];
        endcase
        if (bus.out_valid) begin
          exp_beat(b, n, seen, ed, em, el);
          check({tag, (bus.out_ready ? " beat" : " stalled beat")},
                256'({bus.out_last, bus.out_mask, bus.out_data}), 256'({el, em, ed}));
          if (!bus.out_ready)
            check({tag, " stalled rom_addr"}, 256'(bus.rom_addr),
                  256'(exp_addrs(int'(b) + (seen + 1) * LANES)));
          if (bus.out_ready) begin
            seen++;
            if (bus.out_last) begin
              last_taken = 1;
              last_mask_seen = bus.out_mask;
            end
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!finished) check({tag, " timeout"}, 256'(0), 256'(1));
    check({tag, " beat count"}, 256'(seen), 256'(exp_beats));
    check({tag, " last mask"}, 256'(last_mask_seen), 256'(exp_last_mask));
    check({tag, " busy held / no early done"}, 256'({busy_ok, done_early}), 256'(2'b10));
    @(negedge clk);
    check({tag, " idle after done"}, 256'({busy, done, bus.out_valid}), 256'(3'b000));
  endtask

  typedef struct {
    addr_t           base;
    len_t            len;
    int              mode;
    int              exp_beats;
    logic [LANES-1:0] exp_last_mask;
    bit              poke;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit quiet;
    vecs[0] = '{19'h00000, 20'd30, 0, 3, 10'h3FF, 1'b0};
    vecs[1] = '{19'h00005, 20'd13, 0, 2, 10'h007, 1'b0};
    vecs[2] = '{19'h7FFFC, 20'd10, 0, 1, 10'h3FF, 1'b0};
    vecs[3] = '{19'h00000, 20'd30, 2, 3, 10'h3FF, 1'b0};
    vecs[4] = '{19'h00100, 20'd25, 0, 3, 10'h01F, 1'b1};
    vecs[5] = '{19'h7FFF0, 20'd25, 1, 3, 10'h01F, 1'b0};
    vecs[6] = '{19'h12345, 20'd1,  1, 1, 10'h001, 1'b0};
    vecs[7] = '{19'h00040, 20'd11, 2, 2, 10'h001, 1'b0};

    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 256'({busy, done, bus.out_valid, bus.out_last, bus.out_mask, bus.out_data}),
          256'(0));
    check("reset rom_addr", 256'(bus.rom_addr), 256'(exp_addrs(0)));
    rst = 1'b0;
    @(negedge clk);
    check("idle rom_addr", 256'(bus.rom_addr), 256'(exp_addrs(0)));

    // Zero-length command: done next cycle, never a beat.
    start = 1'b1; length = '0; base_addr = 19'h55; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0 done", 256'({bus.out_valid, done}), 256'(2'b01));
    quiet = 1;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid || done) quiet = 0;
    end
    check("len0 quiet after", 256'(quiet), 256'(1));

    foreach (vecs[i])
      run_transfer($sformatf("vec%0d", i), vecs[i].base, vecs[i].len, vecs[i].mode,
                   vecs[i].exp_beats, vecs[i].exp_last_mask, vecs[i].poke);

    for (int r = 0; r < 6; r++) begin
      addr_t rb;
      len_t  rn;
      int    nb;
      rb = addr_t'($urandom);
      rn = len_t'($urandom_range(1, 70));
      nb = (int'(rn) + 9) / 10;
      run_transfer($sformatf("rand%0d", r), rb, rn, 1, nb,
                   10'((1 << (int'(rn) - (nb - 1) * 10)) - 1), 1'b0);
    end

    // Reset in the middle of beat 2, then a clean transfer.
    bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = '0; length = 20'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst beat2 valid", 256'(bus.out_valid), 256'(1));
    #1 rst = 1'b1;
    #1;
    check("midrst outputs", 256'({bus.out_valid, busy, done}), 256'(3'b000));
    check("midrst rom_addr", 256'(bus.rom_addr), 256'(exp_addrs(0)));
    @(negedge clk);
    rst = 1'b0;
    run_transfer("after rst", 19'h00200, 20'd30, 0, 3, 10'h3FF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
